fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core: owns the program counter, issues one-at-a-time requests to instruction memory over a valid/ready handshake, and holds the fetched word in the IF/ID register whose opcode field drives the decode-stage control unit. It applies branch/jump redirects from downstream, flushing in-flight work, and honours a decode-stage stall.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to
// instruction memory, and holds the fetched word in the IF/ID register.
// Downstream redirects flush in-flight work; a decode stall freezes IF/ID.
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              arst_n,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              imem_rsp_ready,
  input  logic              stall_id,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              ifid_valid,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [31:0]       ifid_instr,
  output logic [6:0]        ifid_opcode
);

  // WAIT: request accepted, response pending and wanted.
  // DROP: request accepted, but a redirect made its response stale.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [ADDR_W-1:0]   ifid_pc_q, ifid_pc_d;
  logic [31:0]         ifid_instr_q, ifid_instr_d;

  logic                redirect_s;
  logic [ADDR_W-1:0]   target_s;
  logic                hold_s;
  logic                req_fire_s;
  logic                rsp_fire_s;
  logic                load_s;

  assign redirect_s = jump | branch_taken;
  assign target_s   = jump ? jump_target : branch_target;
  assign hold_s     = ifid_valid_q & stall_id;

  assign imem_req_valid = (state_q == S_FETCH) & ~hold_s & ~redirect_s;
  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = ((state_q == S_WAIT) & ~hold_s) | (state_q == S_DROP);

  assign req_fire_s = imem_req_valid & imem_req_ready;
  assign rsp_fire_s = imem_rsp_valid & imem_rsp_ready;

  assign ifid_valid  = ifid_valid_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_opcode = ifid_instr_q[6:0];

  // Sequencing of the request/response handshake and PC advance.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redirect_s) begin
          pc_d = target_s;
        end else if (req_fire_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (redirect_s) begin
          pc_d    = target_s;
          state_d = rsp_fire_s ? S_FETCH : S_DROP;
        end else if (rsp_fire_s) begin
          load_s  = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = S_FETCH;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        // A redirect while draining only retargets; the stale response
        // still has to be swallowed before a new request may go out.
        if (redirect_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
        if (rsp_fire_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // IF/ID update: flush beats load, load beats consume, stall holds.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    if (redirect_s) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
    end else if (load_s) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_instr_d = imem_rsp_data;
    end else if (!stall_id) begin
      ifid_valid_d = 1'b0;
    end else begin
      ifid_valid_d = ifid_valid_q;
    end
  end

  // State, PC and IF/ID registers with asynchronous reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized run,
// all checked against a transaction-level model of the fetch stage and an
// instruction memory model that returns a pure function of the address.
module tb_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h0000_0000_0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_ready;
  logic        stall_id = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = 64'h0;
  logic        jump = 1'b0;
  logic [63:0] jump_target = 64'h0;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [6:0]  ifid_opcode;

  fetch_unit #(
    .ADDR_W    (64),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_ready (imem_rsp_ready),
    .stall_id       (stall_id),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_opcode    (ifid_opcode)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus knobs
  logic        st = 1'b0, jp = 1'b0, br = 1'b0, rdy = 1'b1;
  logic [63:0] jt = 64'h0, bt = 64'h0;
  int          lat = 1;

  // reference model (transaction level)
  logic        m_valid, m_out, m_drain, m_bubble;
  logic [63:0] m_pc, m_next_pc, m_req_addr;
  logic [31:0] m_instr;
  int          mcnt;

  // observation logs
  logic        obs_req_v;
  logic [63:0] obs_req_addr;
  logic [63:0] req_log[$];
  logic        vlog[$];
  logic [63:0] plog[$];
  logic [31:0] tmp_w;

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid    = 1'b0;
    m_pc       = 64'h0;
    m_instr    = NOP;
    m_next_pc  = RST_PC;
    m_out      = 1'b0;
    m_drain    = 1'b0;
    m_bubble   = 1'b1;
    m_req_addr = 64'h0;
    mcnt       = 0;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react at once.
  task automatic do_reset();
    #2;
    arst_n = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; stall_id = 1'b0;
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
    chk("rst_rsp_ready", 64'(imem_rsp_ready), 64'h0);
    chk("rst_ifid_valid", 64'(ifid_valid), 64'h0);
    chk("rst_ifid_pc", ifid_pc, 64'h0);
    chk("rst_ifid_instr", 64'(ifid_instr), 64'(NOP));
    chk("rst_req_addr", imem_req_addr, RST_PC);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  // One clock: drive, check handshake outputs, clock, check IF/ID.
  task automatic cycle();
    logic        e_hold, redir, e_req_v, e_rsp_r, rq_fire, rs_fire;
    logic [63:0] tgt, req_addr_now;
    if (m_out && mcnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_f(m_req_addr);
    end else begin
      if (m_out) mcnt--;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    stall_id       = st;
    jump           = jp;
    jump_target    = jt;
    branch_taken   = br;
    branch_target  = bt;
    imem_req_ready = rdy;
    #4;
    e_hold  = m_valid & st;
    redir   = jp | br;
    tgt     = jp ? jt : bt;
    e_req_v = ~m_bubble & ~m_out & ~e_hold & ~redir;
    e_rsp_r = m_out & (m_drain | ~e_hold);
    chk("req_valid", 64'(imem_req_valid), 64'(e_req_v));
    chk("rsp_ready", 64'(imem_rsp_ready), 64'(e_rsp_r));
    chk("req_addr", imem_req_addr, m_next_pc);
    obs_req_v    = imem_req_valid;
    obs_req_addr = imem_req_addr;
    if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    rq_fire      = e_req_v & rdy;
    rs_fire      = e_rsp_r & imem_rsp_valid;
    req_addr_now = m_next_pc;
    @(posedge clk);
    #1;
    if (redir) begin
      m_valid   = 1'b0;
      m_instr   = NOP;
      m_next_pc = tgt;
      if (rs_fire) begin
        m_out = 1'b0; m_drain = 1'b0;
      end else if (m_out) begin
        m_drain = 1'b1;
      end
    end else begin
      if (rs_fire && !m_drain) begin
        m_valid   = 1'b1;
        m_pc      = m_req_addr;
        m_instr   = mem_f(m_req_addr);
        m_next_pc = m_req_addr + 64'd4;
      end else if (!st) begin
        m_valid = 1'b0;
      end
      if (rs_fire) begin
        m_out = 1'b0; m_drain = 1'b0;
      end
    end
    if (rq_fire) begin
      m_out      = 1'b1;
      m_req_addr = req_addr_now;
      mcnt       = lat - 1;
    end
    m_bubble = 1'b0;
    chk("ifid_valid", 64'(ifid_valid), 64'(m_valid));
    chk("ifid_pc", ifid_pc, m_pc);
    chk("ifid_instr", 64'(ifid_instr), 64'(m_instr));
    chk("ifid_opcode", 64'(ifid_opcode), 64'(m_instr[6:0]));
    vlog.push_back(ifid_valid);
    plog.push_back(ifid_pc);
  endtask

  initial begin
    model_reset();

    // Reset flow and zero-wait streaming from RESET_PC.
    do_reset();
    req_log.delete(); vlog.delete(); plog.delete();
    lat = 1; rdy = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("t1_nreq", 64'(req_log.size()), 64'd3);
    chk("t1_req0", req_log[0], 64'h100);
    chk("t1_req1", req_log[1], 64'h104);
    chk("t1_req2", req_log[2], 64'h108);
    chk("t1_vpat", 64'({vlog[0], vlog[1], vlog[2], vlog[3], vlog[4], vlog[5]}), 64'b001010);
    chk("t1_pc_a", plog[2], 64'h100);
    chk("t1_pc_b", plog[4], 64'h104);
    tmp_w = mem_f(64'h104);
    chk("t1_opcode", 64'(ifid_opcode), 64'(tmp_w[6:0]));

    // Decode stall with a live instruction freezes IF/ID and the PC.
    cycle();
    chk("t2_loaded", ifid_pc, 64'h108);
    st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_hold_pc", ifid_pc, 64'h108);
      chk("t2_hold_v", 64'(ifid_valid), 64'h1);
      chk("t2_no_req", 64'(obs_req_v), 64'h0);
      chk("t2_pc_frozen", obs_req_addr, 64'h10C);
    end
    st = 1'b0;
    cycle();
    cycle();
    chk("t2_next_pc", ifid_pc, 64'h10C);
    cycle();
    cycle();
    chk("t2_nreq", 64'(req_log.size()), 64'd5);
    chk("t2_req3", req_log[3], 64'h10C);
    chk("t2_req4", req_log[4], 64'h110);

    // Branch while waiting: stale response drained, then fetch at target.
    lat = 3;
    cycle();
    chk("t3_req", req_log[req_log.size()-1], 64'h114);
    br = 1'b1; bt = 64'h200;
    cycle();
    br = 1'b0;
    chk("t3_flush_v", 64'(ifid_valid), 64'h0);
    chk("t3_flush_i", 64'(ifid_instr), 64'(NOP));
    cycle();
    chk("t3_drop_noreq", 64'(obs_req_v), 64'h0);
    cycle();
    chk("t3_discard_v", 64'(ifid_valid), 64'h0);
    chk("t3_discard_i", 64'(ifid_instr), 64'(NOP));
    lat = 1;
    cycle();
    chk("t3_target", req_log[req_log.size()-1], 64'h200);

    // Jump and branch together on the response handshake: jump wins.
    jp = 1'b1; jt = 64'h400; br = 1'b1; bt = 64'h300;
    cycle();
    jp = 1'b0; br = 1'b0;
    chk("t4_flush_v", 64'(ifid_valid), 64'h0);
    chk("t4_flush_i", 64'(ifid_instr), 64'(NOP));
    cycle();
    chk("t4_req_v", 64'(obs_req_v), 64'h1);
    chk("t4_target", req_log[req_log.size()-1], 64'h400);

    // Memory back-pressure, then PC wrap at the top of the address space.
    rdy = 1'b0; jp = 1'b1; jt = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    jp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_req_held", 64'(obs_req_v), 64'h1);
      chk("t5_addr_held", obs_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    end
    rdy = 1'b1;
    cycle();
    cycle();
    chk("t5_top_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    lat = 3;
    cycle();
    chk("t5_wrap", req_log[req_log.size()-1], 64'h0);

    // Reset pulse while a response is pending.
    cycle();
    do_reset();
    lat = 1;
    cycle();
    chk("t6_bubble", 64'(obs_req_v), 64'h0);
    cycle();
    chk("t6_first_v", 64'(obs_req_v), 64'h1);
    chk("t6_first_a", req_log[req_log.size()-1], RST_PC);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < 7);
      lat = $urandom_range(1, 3);
      jp  = ($urandom_range(0, 19) == 0);
      br  = ($urandom_range(0, 19) == 0);
      jt  = {$urandom, $urandom & 32'hFFFF_FFFC};
      bt  = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {32'h0, $urandom & 32'hFFFF_FFFC};
      cycle();
    end
    jp = 1'b0; br = 1'b0; st = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
